score_bank: RTL
===============

SCORE_BANK -- requirements
Module: score_bank

Interface
Parameters:
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per score.
REQ-002 The block SHALL have parameter PLAYERS, default 2, giving the number of independent score channels.
REQ-003 The block SHALL have parameter QDEPTH, default 4, giving the request FIFO depth (power of 2, >=2).
Ports (PW = max(1, clog2(PLAYERS))):
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 add  input  1  request valid.
REQ-007 player  input  PW  target channel of the request.
REQ-008 sum  input  [DIGITS-1:0][3:0]  BCD increment.
REQ-009 ready  output  1  high when the FIFO can accept a request.
REQ-010 clear  input  1  synchronous zeroing of all scores.
REQ-011 busy  output  1  high when the FIFO is non-empty or the engine is not IDLE.
REQ-012 score  output  [PLAYERS-1:0][DIGITS-1:0][3:0]  current BCD score per channel.
REQ-013 high_score  output  [DIGITS-1:0][3:0]  session best score.

Function
REQ-014 A request SHALL be accepted on a rising edge where add && ready && !clear; ready = FIFO not full.
REQ-015 On enqueue, each sum digit above 9 SHALL be clamped to 9; a player index >= PLAYERS SHALL cause the request to be dropped (ready unaffected).
REQ-016 The engine SHALL have states IDLE, ADD, WRITE: IDLE->ADD when FIFO non-empty (pop, latch player/sum/current score); ADD runs DIGITS cycles, one digit per cycle LSD first with carry; ADD->WRITE after digit DIGITS-1; WRITE->IDLE.
REQ-017 Digit addition SHALL be BCD: d = a+b+cin; if d>9 then out = d-10, cout = 1.
REQ-018 If carry out of the MSD is 1, the stored result SHALL saturate to all 9s.
REQ-019 In WRITE the result SHALL be written to score[player]; no other channel changes.
REQ-020 With idle engine and empty FIFO, score SHALL reflect a request accepted at edge T at edge T+DIGITS+2.
REQ-021 FIFO SHALL support simultaneous push and pop when full (ready stays high only if not full after the pop is accounted on that edge; ready is combinational from registered count, no bypass).
REQ-022 Requests SHALL be processed strictly in acceptance order; consecutive requests to the same player SHALL each see the previous result.
REQ-023 clear SHALL have priority over all: on that edge all scores go to 0, the FIFO is flushed, an in-flight operation is discarded, the engine goes to IDLE, high_score is retained.

Reset
REQ-024 On resetN low, asynchronously: score all 0, high_score 0, FIFO empty, state IDLE, busy 0, ready 1.
REQ-025 Reset asserted mid-operation SHALL discard the operation and all queued requests; nothing resumes after release.

Configuration
REQ-026 Macro SCORE_BANK_HIGH_SCORE_EN: when defined, in WRITE high_score SHALL take the written value if it is strictly greater (BCD compare) than high_score, compared after saturation.
REQ-027 When SCORE_BANK_HIGH_SCORE_EN is not defined, the port SHALL remain and be driven constant 0, with no compare logic.

Verification (DIGITS=4, PLAYERS=2, QDEPTH=4)
REQ-028 Reset, then add player0 sum 0x0095 -> score[0]=0x0095 at edge T+6, busy low after, score[1]=0.
REQ-029 Player1 holds 0x9990, add 0x0025 -> score[1]=0x9999 (saturated), high_score=0x9999 with macro, 0 without.
REQ-030 Hold add high for 6 cycles, engine busy -> ready falls after 4 queued + 1 in flight as specified, all accepted requests applied in order, none lost.
REQ-031 Player0 0x0000, add 0x00A7 -> digit clamped, score[0]=0x0097.
REQ-032 Assert clear during ADD with 2 queued -> next edge scores 0, busy 0, ready 1, high_score unchanged; later requests work normally.
REQ-033 Assert resetN low during ADD -> immediate zero scores, IDLE, queue empty.

Source files
------------

// File: rtl/score_bank.sv
// Multi-channel BCD score accumulator: request FIFO feeding a digit-serial BCD adder.
// Optional session high-score tracking enabled by defining SCORE_BANK_HIGH_SCORE_EN.
module score_bank #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned QDEPTH  = 4,
    localparam int unsigned PW     = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                add,
    input  logic [PW-1:0]                       player,
    input  logic [DIGITS-1:0][3:0]              sum,
    output logic                                ready,
    input  logic                                clear,
    output logic                                busy,
    output logic [PLAYERS-1:0][DIGITS-1:0][3:0] score,
    output logic [DIGITS-1:0][3:0]              high_score
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef struct packed {
        logic [PW-1:0]          player;
        logic [DIGITS-1:0][3:0] sum;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    req_t                                r_mem [QDEPTH];
    logic [AW-1:0]                       r_wr_ptr;
    logic [AW-1:0]                       r_rd_ptr;
    logic [CW-1:0]                       r_count;
    state_t                              r_state;
    state_t                              w_state_nxt;
    logic                                w_pop;
    logic                                w_push;
    logic                                w_player_ok;
    req_t                                w_in;
    req_t                                w_head;
    logic [PW-1:0]                       r_player;
    logic [DIGITS-1:0][3:0]              r_a;
    logic [DIGITS-1:0][3:0]              r_b;
    logic [DIGITS-1:0][3:0]              r_res;
    logic [DIGITS-1:0][3:0]              w_result;
    logic [DW-1:0]                       r_digit;
    logic                                r_carry;
    logic [3:0]                          w_da;
    logic [3:0]                          w_db;
    logic [3:0]                          w_dout;
    logic [4:0]                          w_dsum;
    logic                                w_cout;
    logic [PLAYERS-1:0][DIGITS-1:0][3:0] r_score;

    // Out-of-range player indices only exist when PLAYERS is not a power of two.
    generate
        if ((32'd1 << PW) == PLAYERS) begin : g_all_ok
            assign w_player_ok = 1'b1;
        end else begin : g_range_chk
            assign w_player_ok = (player < PW'(PLAYERS));
        end
    endgenerate

    assign ready  = (r_count != CW'(QDEPTH));
    assign busy   = (r_count != '0) || (r_state != S_IDLE);
    assign w_push = add && ready && !clear && w_player_ok;
    assign w_head = r_mem[r_rd_ptr];
    assign score  = r_score;

    always_comb begin
        w_in.player = player;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_in.sum[i] = (sum[i] > 4'd9) ? 4'd9 : sum[i];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    // One BCD digit per cycle; MSD carry saturates the result to all nines
    always_comb begin
        w_da   = r_a[r_digit];
        w_db   = r_b[r_digit];
        w_dsum = 5'(w_da) + 5'(w_db) + 5'(r_carry);
        w_dout = w_dsum[3:0];
        w_cout = 1'b0;
        if (w_dsum > 5'd9) begin
            w_dout = 4'(w_dsum - 5'd10);
            w_cout = 1'b1;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_result[i] = r_carry ? 4'd9 : r_res[i];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        w_state_nxt = S_ADD;
                        w_pop       = 1'b1;
                    end
                end
                S_ADD:   if (r_digit == DW'(DIGITS - 1)) w_state_nxt = S_WRITE;
                S_WRITE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand latch, digit accumulation and score write-back
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_player <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_digit  <= '0;
            r_carry  <= 1'b0;
            r_score  <= '0;
        end else if (clear) begin
            r_score  <= '0;
            r_digit  <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_player <= w_head.player;
                        r_a      <= r_score[w_head.player];
                        r_b      <= w_head.sum;
                        r_res    <= '0;
                        r_digit  <= '0;
                        r_carry  <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_res[r_digit] <= w_dout;
                    r_carry        <= w_cout;
                    r_digit        <= r_digit + DW'(1);
                end
                S_WRITE: r_score[r_player] <= w_result;
                default: ;
            endcase
        end
    end

`ifdef SCORE_BANK_HIGH_SCORE_EN
    logic [DIGITS-1:0][3:0] r_high;

    // Valid BCD orders the same as plain binary, so a vector compare suffices
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_high <= '0;
        end else if (!clear && (r_state == S_WRITE) && (w_result > r_high)) begin
            r_high <= w_result;
        end
    end

    assign high_score = r_high;
`else
    assign high_score = '0;
`endif

endmodule
